// File: rtl/pingpong_ctrl.sv
// Ping-pong bank sequencer between an SPI writer (producer) and a DSP (consumer).
// Optional PROC watchdog is built only when PINGPONG_CTRL_WDOG_EN is defined.
module pingpong_ctrl #(
    parameter int DRAIN_CYC = 3,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fill_done,
    input  logic        proc_done,
    input  logic        err_clr,
    output logic        wr_bank,
    output logic        wr_ready,
    output logic        rd_bank,
    output logic        dsp_ready,
    output logic [1:0]  full,
    output logic [15:0] frame_cnt,
    output logic        ovf,
    output logic        wdog_err
);

    if (DRAIN_CYC < 1 || DRAIN_CYC > 15 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_check
        $error("pingpong_ctrl: DRAIN_CYC or TIMEOUT out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROC  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  drain_cnt_q, drain_cnt_d;
    logic [1:0]  full_q, full_d;
    logic        wr_bank_q;
    logic        rd_bank_q;
    logic [15:0] frame_cnt_q;
    logic        ovf_q;

    logic        fill_accept;
    logic        fill_reject;
    logic        release_bank;
    logic        wdog_fire;

    // Fill decisions use the pre-edge full value, so a same-cycle release of wr_bank rejects.
    assign fill_accept = fill_done & ~full_q[wr_bank_q];
    assign fill_reject = fill_done &  full_q[wr_bank_q];

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        release_bank = 1'b0;
        case (state_q)
            IDLE: begin
                drain_cnt_d = '0;
                if (full_q[rd_bank_q]) begin
                    state_d = PROC;
                end
            end
            PROC: begin
                drain_cnt_d = '0;
                if (proc_done || wdog_fire) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    release_bank = 1'b1;
                    drain_cnt_d  = '0;
                    state_d      = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                drain_cnt_d = '0;
            end
        endcase
    end

    // Release and accept touch different banks unless wr_bank == rd_bank, where accept is already blocked.
    always_comb begin
        full_d = full_q;
        if (release_bank) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (fill_accept) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            full_q      <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            full_q      <= full_d;
            if (fill_accept) begin
                wr_bank_q <= ~wr_bank_q;
            end
            if (release_bank) begin
                rd_bank_q   <= ~rd_bank_q;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (fill_reject) begin
                ovf_q <= 1'b1;
            end else if (err_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef PINGPONG_CTRL_WDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    logic [15:0] wdog_cnt_q;
    logic        wdog_err_q;

    // Fires on the edge that completes TIMEOUT cycles of PROC; proc_done on that edge takes precedence.
    assign wdog_fire = (state_q == PROC) && !proc_done && (wdog_cnt_q == WDOG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            if (state_q == PROC && state_d == PROC) begin
                wdog_cnt_q <= wdog_cnt_q + 16'd1;
            end else begin
                wdog_cnt_q <= '0;
            end
            if (wdog_fire) begin
                wdog_err_q <= 1'b1;
            end else if (err_clr) begin
                wdog_err_q <= 1'b0;
            end
        end
    end

    assign wdog_err = wdog_err_q;
`else
    assign wdog_fire = 1'b0;
    assign wdog_err  = 1'b0;
`endif

    assign wr_bank   = wr_bank_q;
    assign rd_bank   = rd_bank_q;
    assign full      = full_q;
    assign wr_ready  = ~full_q[wr_bank_q];
    assign dsp_ready = (state_q == PROC);
    assign frame_cnt = frame_cnt_q;
    assign ovf       = ovf_q;

endmodule
